// File: rtl/icache_pkg.sv
// Shared types for the instruction cache: address view, frame layout and FSM states.
package icache_pkg;

  localparam int unsigned SETS  = 16;
  localparam int unsigned IDX   = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX;
  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX-1:0]   idx;
    logic [1:0]       bytoff;
  } icachef_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-block instruction cache with miss-fill FSM,
// full flush and a saturating miss counter.
module icache
  import icache_pkg::*;
#(
  parameter logic [CNT_W-1:0] MISS_MAX = 16'hFFFF
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic             ihit,
  output logic [31:0]      imemload,
  input  logic             flush,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic [CNT_W-1:0] miss_count
);

  icache_frame_t frames [SETS];
  icache_state_t state, state_n;
  icachef_t      maddr, maddr_n;
  logic [CNT_W-1:0] cnt_n;
  icachef_t      addr;
  icache_frame_t frame;
  logic          hit;
  logic          fill_we;
  logic          unused_bits;

  // Lookup: byte offset is ignored, tag compare is full width.
  always_comb begin
    addr        = icachef_t'(imemaddr);
    frame       = frames[addr.idx];
    hit         = imemREN && (state == IDLE) && frame.valid &&
                  (frame.tag == addr.tag) && !flush;
    ihit        = hit;
    imemload    = hit ? frame.data : 32'h0;
    unused_bits = ^addr.bytoff;
  end

  always_comb begin
    state_n = state;
    maddr_n = maddr;
    cnt_n   = miss_count;
    fill_we = 1'b0;
    iREN    = 1'b0;
    iaddr   = 32'h0;
    case (state)
      IDLE: begin
        if (imemREN && !hit && !flush) begin
          maddr_n = '{tag: addr.tag, idx: addr.idx, bytoff: 2'b00};
          state_n = FETCH;
          if (miss_count != MISS_MAX) cnt_n = miss_count + CNT_W'(1);
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = 32'(maddr);
        // Flush aborts the fill outright, even if data arrives this cycle.
        if (flush) begin
          state_n = IDLE;
        end else if (!iwait) begin
          fill_we = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      maddr      <= '0;
      miss_count <= '0;
      for (int i = 0; i < int'(SETS); i++) frames[i] <= '0;
    end else begin
      state      <= state_n;
      maddr      <= maddr_n;
      miss_count <= cnt_n;
      if (flush) begin
        for (int i = 0; i < int'(SETS); i++) frames[i].valid <= 1'b0;
      end else if (fill_we) begin
        frames[maddr.idx] <= '{valid: 1'b1, tag: maddr.tag, data: iload};
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: drivers push expected fetch data, a negedge
// monitor pops and compares on every ihit.
module tb_icache;

  localparam logic [15:0] SAT = 16'h00FF;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'h0;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush = 1'b0;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [15:0] miss_count;

  int          vectors = 0;
  int          errors  = 0;
  int          wait_cfg = 0;
  int          wcnt = 0;
  logic [15:0] exp_cnt = 16'h0;
  logic [31:0] exp_q [$];

  icache #(.MISS_MAX(SAT)) u_dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  // Memory model: wait_cfg busy cycles per request, fixed data map.
  always @(posedge CLK) begin
    if (!iREN) wcnt <= 0;
    else       wcnt <= wcnt + 1;
  end
  assign iwait = iREN && (wcnt < wait_cfg);
  assign iload = (iaddr == 32'h40) ? 32'h2001_0005 :
                 (iaddr == 32'h80) ? 32'hDEAD_BEEF : (iaddr ^ 32'h1234_0000);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: data check on every hit, plus protocol sanity.
  always @(negedge CLK) begin
    if (nRST) begin
      if (ihit) begin
        if (exp_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL unexpected_hit: got %h want none", imemload);
        end else begin
          chk("hit_data", imemload, exp_q.pop_front());
        end
        if (iREN) begin
          errors++;
          $display("FAIL hit_in_fetch: got ihit=1 with iREN=1 want ihit=0");
        end
      end else if (imemload != 32'h0) begin
        errors++;
        $display("FAIL load_no_hit: got %h want 0", imemload);
      end
    end
  end

  task automatic wait_hit(output int cyc, output int ren, output logic [31:0] seen, output bit got);
    cyc = 0; ren = 0; seen = 32'h0; got = 0;
    while (cyc < 64 && !got) begin
      @(negedge CLK);
      if (ihit) got = 1;
      else begin
        if (iREN) begin ren++; seen = iaddr; end
        cyc++;
      end
    end
    if (!got) chk("timeout", 32'h0, 32'h1);
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input bit miss, input int w);
    int cyc, ren;
    logic [31:0] seen;
    bit got;
    exp_q.push_back(d);
    wait_cfg = w;
    imemREN  = 1'b1;
    imemaddr = a;
    wait_hit(cyc, ren, seen, got);
    chk("latency", 32'(cyc), miss ? 32'(2 + w) : 32'h0);
    chk("iren_cycles", 32'(ren), miss ? 32'(1 + w) : 32'h0);
    if (miss) begin
      chk("iaddr", seen, {a[31:2], 2'b00});
      if (exp_cnt != SAT) exp_cnt = exp_cnt + 16'h1;
    end
    chk("miss_count", 32'(miss_count), 32'(exp_cnt));
    @(posedge CLK); #1;
    imemREN = 1'b0;
  endtask

  initial begin
    int cyc, ren;
    logic [31:0] seen;
    bit got;
    #12;
    chk("rst_ihit", 32'(ihit), 32'h0);
    chk("rst_iren", 32'(iREN), 32'h0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_load", imemload, 32'h0);
    chk("rst_cnt", 32'(miss_count), 32'h0);
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;

    // Cold miss, hit, conflict eviction
    fetch(32'h0000_0043, 32'h2001_0005, 1, 2);
    fetch(32'h0000_0040, 32'h2001_0005, 0, 0);
    fetch(32'h0000_0080, 32'hDEAD_BEEF, 1, 0);
    fetch(32'h0000_0040, 32'h2001_0005, 1, 1);
    chk("conflict_cnt", 32'(miss_count), 32'h3);

    // Redirect during FETCH: fill completes to 0x100, then 0x200 misses
    exp_q.push_back(32'h1234_0200);
    wait_cfg = 2; imemREN = 1'b1; imemaddr = 32'h100;
    @(negedge CLK); chk("redir_miss_ihit", 32'(ihit), 32'h0);
    @(posedge CLK); #1; imemaddr = 32'h200;
    @(negedge CLK); chk("redir_iaddr", iaddr, 32'h100);
    wait_hit(cyc, ren, seen, got);
    chk("redir_iaddr2", seen, 32'h200);
    exp_cnt = exp_cnt + 16'h2;
    chk("redir_cnt", 32'(miss_count), 32'(exp_cnt));
    @(posedge CLK); #1; imemREN = 1'b0;

    // Flush pulse invalidates 0x200
    fetch(32'h0000_0200, 32'h1234_0200, 0, 0);
    flush = 1'b1;
    @(posedge CLK); #1; flush = 1'b0;
    fetch(32'h0000_0200, 32'h1234_0200, 1, 1);

    // Flush in FETCH with iwait=0: no fill, back to IDLE
    wait_cfg = 0; imemREN = 1'b1; imemaddr = 32'h300;
    @(posedge CLK); #1; flush = 1'b1; imemREN = 1'b0;
    @(negedge CLK); chk("abort_fetch", 32'(iREN), 32'h1);
    @(posedge CLK); #1; flush = 1'b0;
    @(negedge CLK); chk("abort_idle", 32'(iREN), 32'h0);
    exp_cnt = exp_cnt + 16'h1;
    chk("abort_cnt", 32'(miss_count), 32'(exp_cnt));
    @(posedge CLK); #1;
    fetch(32'h0000_0300, 32'h1234_0300, 1, 0);

    // Saturation: distinct tags in idx 1, more misses than the limit
    for (int i = 0; i < 300; i++) begin
      fetch(32'h1004 + 32'(i * 64), (32'h1004 + 32'(i * 64)) ^ 32'h1234_0000, 1, 0);
    end
    chk("sat_cnt", 32'(miss_count), 32'(SAT));

    // Reset in the middle of FETCH
    wait_cfg = 5; imemREN = 1'b1; imemaddr = 32'h500;
    @(negedge CLK);
    @(negedge CLK); chk("pre_rst_iren", 32'(iREN), 32'h1);
    #2 nRST = 1'b0;
    #1;
    chk("mid_rst_iren", 32'(iREN), 32'h0);
    chk("mid_rst_ihit", 32'(ihit), 32'h0);
    chk("mid_rst_cnt", 32'(miss_count), 32'h0);
    imemREN = 1'b0; exp_cnt = 16'h0;
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
    fetch(32'h0000_0300, 32'h1234_0300, 1, 0);

    @(negedge CLK);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, one-word-block instruction cache between the pipelined datapath's fetch port and the memory controller's instruction port. Serves fetches on hit combinationally in the same cycle. Runs a miss-fill state machine against the memory controller on a miss and raises ihit once the frame is filled. Supports a full flush and exports a saturating miss counter for performance runs.

## Interface
- SETS, 16, number of frames; power of two; index width IDX = log2(SETS)
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- imemREN  in  1  datapath fetch request
- imemaddr  in  32  fetch byte address; bits [1:0] ignored
- ihit  out  1  fetch data valid this cycle
- imemload  out  32  fetched instruction; 0 when ihit=0
- flush  in  1  invalidate all frames, one cycle pulse or level
- iREN  out  1  memory read request
- iaddr  out  32  memory word address, [1:0]=00
- iwait  in  1  memory busy; iload valid in a cycle with iREN=1 and iwait=0
- iload  in  32  memory read data
- miss_count  out  16  number of misses since reset, saturating

## Operation
- Address split: tag = imemaddr[31:IDX+2], idx = imemaddr[IDX+1:2].
- Frame: valid, tag (30-IDX bits), data (32).
- hit = imemREN & state==IDLE & valid[idx] & tag match & ~flush; ihit = hit; imemload = hit ? data[idx] : 0.
- States: IDLE, FETCH.
- IDLE: on imemREN & ~hit & ~flush, latch miss address (word aligned) into maddr, go FETCH, increment miss_count unless 0xFFFF.
- FETCH: iREN=1, iaddr=maddr. When iwait=0: write valid=1, tag/data from maddr/iload into frame maddr idx; go IDLE.
- In IDLE, iREN=0, iaddr=0.
- The fill completes to maddr even if imemaddr changes or imemREN drops during FETCH; a redirected PC is re-looked-up in IDLE afterwards.
- flush: clears all valid bits at the next edge. In FETCH, flush aborts the fill: no frame write, go IDLE; iREN drops the following cycle.
- Flush and fill completion in the same cycle: flush wins, frame stays invalid.
- Tag compare is always full width; no partial match.

## Timing
- Reset: all valid=0, frame tag/data=0, state=IDLE, maddr=0, miss_count=0. Outputs during reset: ihit=0, imemload=0, iREN=0, iaddr=0.
- Hit latency 0: ihit in the same cycle as the request.
- Miss latency: request cycle t is the miss (IDLE). t+1 is FETCH with iREN=1. The fill writes at the edge ending the first FETCH cycle with iwait=0, at t+1+W for W wait cycles. ihit is asserted at t+2+W.
- ihit is never asserted while state=FETCH.
- Reset asserted mid-FETCH: immediate return to reset values; the in-flight memory read is dropped.

## Structure
- Shared package cpu_types_pkg gains icachef_t (packed tag/idx/bytoff address view) and icache_frame_t (valid, tag, data). The datapath-side signals are grouped in the existing datapath-cache interface. The memory-side signals are grouped in the existing cache-controller interface.
- Single module; frame array as a register array reset in the async block. No sub-module.

## Test plan
- Cold miss: reset, imemREN=1, imemaddr=0x0000_0040, iwait=1 for 2 cycles, iload=0x2001_0005 -> iREN high for 3 cycles with iaddr=0x40, ihit at cycle 4, imemload=0x2001_0005, miss_count=1.
- Hit after fill: same address again -> ihit same cycle, no iREN, miss_count unchanged.
- Conflict: fill 0x40, then 0x80 (SETS=16, same idx 0) with iload=0xDEAD_BEEF -> miss. 0x80 returns 0xDEADBEEF; then 0x40 misses again, miss_count=3.
- Redirect mid-fill: miss on 0x100, change imemaddr to 0x200 during FETCH -> fill writes frame for 0x100. Then 0x200 misses; no ihit for 0x200 from 0x100's data.
- Flush: fill 0x40, pulse flush, re-read 0x40 -> miss. Flush during FETCH with iwait=0 the same cycle -> no frame written, state IDLE.
- Saturation/reset: force 0x10000 misses -> miss_count holds 0xFFFF. Assert nRST mid-FETCH -> iREN=0 and ihit=0 immediately, all frames invalid.
